// File: rtl/dmem_pkg.sv
// Shared types and constants for the CPU data-memory store buffer.
package dmem_pkg;

    localparam int unsigned DMEM_AW = 16;
    localparam int unsigned DMEM_DW = 16;

    localparam logic RW_READ  = 1'b1;
    localparam logic RW_WRITE = 1'b0;

    typedef enum logic {
        StIdle,
        StResp
    } dmem_state_e;

    typedef struct packed {
        logic [DMEM_AW-1:0] addr;
        logic [DMEM_DW-1:0] data;
    } dmem_entry_t;

endpackage

// File: rtl/store_buf_fifo.sv
// Posted-store FIFO: circular storage with head/tail pointers, occupancy count and a
// youngest-entry address match used for load forwarding.
module store_buf_fifo
    import dmem_pkg::*;
#(
    parameter int unsigned AW    = DMEM_AW,
    parameter int unsigned DW    = DMEM_DW,
    parameter int unsigned DEPTH = 4
) (
    input  logic          ck_i,
    input  logic          rst_i,
    input  logic          push_i,
    input  logic [AW-1:0] push_addr_i,
    input  logic [DW-1:0] push_data_i,
    input  logic          pop_i,
    input  logic [AW-1:0] lookup_addr_i,
    output logic [AW-1:0] head_addr_o,
    output logic [DW-1:0] head_data_o,
    output logic          hit_o,
    output logic [DW-1:0] hit_data_o,
    output logic          full_o,
    output logic          empty_o
);

    localparam int unsigned PtrW = $clog2(DEPTH);
    localparam int unsigned CntW = $clog2(DEPTH + 1);

    logic [AW-1:0]   addr_q [DEPTH];
    logic [DW-1:0]   data_q [DEPTH];
    logic [PtrW-1:0] wr_ptr_q, rd_ptr_q;
    logic [CntW-1:0] count_q, count_d;
    logic [PtrW-1:0] idx;

    always_comb begin
        count_d = count_q;
        unique case ({push_i, pop_i})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge ck_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            for (int i = 0; i < int'(DEPTH); i++) begin
                addr_q[i] <= '0;
                data_q[i] <= '0;
            end
        end else begin
            if (push_i) begin
                addr_q[wr_ptr_q] <= push_addr_i;
                data_q[wr_ptr_q] <= push_data_i;
                wr_ptr_q         <= wr_ptr_q + 1'b1;
            end
            if (pop_i) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            count_q <= count_d;
        end
    end

    // Walk from oldest to youngest so the last match seen is the youngest one.
    always_comb begin
        hit_o      = 1'b0;
        hit_data_o = '0;
        idx        = '0;
        for (int i = 0; i < int'(DEPTH); i++) begin
            idx = rd_ptr_q + PtrW'(i);
            if ((CntW'(i) < count_q) && (addr_q[idx] == lookup_addr_i)) begin
                hit_o      = 1'b1;
                hit_data_o = data_q[idx];
            end
        end
    end

    assign head_addr_o = addr_q[rd_ptr_q];
    assign head_data_o = data_q[rd_ptr_q];
    assign full_o      = (count_q == CntW'(DEPTH));
    assign empty_o     = (count_q == '0);

endmodule

// File: rtl/dmem_store_buffer.sv
// Write-buffered data-memory port: posts CPU stores, drains them to RAM when the port is
// free, and answers loads by forwarding from the buffer or reading RAM.
module dmem_store_buffer
    import dmem_pkg::*;
#(
    parameter int unsigned AW    = DMEM_AW,
    parameter int unsigned DW    = DMEM_DW,
    parameter int unsigned DEPTH = 4
) (
    input  logic          ck_i,
    input  logic          rst_i,
    input  logic [AW-1:0] da_i,
    input  logic [DW-1:0] dwr_i,
    input  logic          rw_i,
    input  logic          vld_i,
    output logic          stall_o,
    output logic [DW-1:0] drd_o,
    output logic          rdv_o,
    input  logic          flush_i,
    output logic          empty_o,
    input  logic          mgnt_i,
    output logic [AW-1:0] ma_o,
    output logic [DW-1:0] mwd_o,
    output logic          mwe_o,
    output logic          mre_o,
    input  logic [DW-1:0] mrd_i
);

    dmem_state_e   state_q, state_d;
    logic          hit_q, hit_d;
    logic [DW-1:0] fwd_q, fwd_d;

    logic          is_ld, is_st, ld_hit, ld_miss, miss_go, ld_go;
    logic          pop, push;
    logic          fifo_hit, fifo_full, fifo_empty;
    logic [DW-1:0] fifo_hit_data, head_data;
    logic [AW-1:0] head_addr;

    store_buf_fifo #(
        .AW    (AW),
        .DW    (DW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .ck_i          (ck_i),
        .rst_i         (rst_i),
        .push_i        (push),
        .push_addr_i   (da_i),
        .push_data_i   (dwr_i),
        .pop_i         (pop),
        .lookup_addr_i (da_i),
        .head_addr_o   (head_addr),
        .head_data_o   (head_data),
        .hit_o         (fifo_hit),
        .hit_data_o    (fifo_hit_data),
        .full_o        (fifo_full),
        .empty_o       (fifo_empty)
    );

    assign is_ld   = vld_i && (rw_i == RW_READ);
    assign is_st   = vld_i && (rw_i == RW_WRITE);
    assign ld_hit  = is_ld && fifo_hit;
    assign ld_miss = is_ld && !fifo_hit;
    assign miss_go = ld_miss && mgnt_i;
    assign ld_go   = ld_hit || miss_go;

    // A load miss only bypasses non-matching stores, so it may take the port ahead of a drain.
    assign pop  = !fifo_empty && mgnt_i && !ld_miss;
    assign push = is_st && !flush_i && (!fifo_full || pop);

    assign stall_o = (ld_miss && !mgnt_i) || (is_st && !push);

    always_comb begin
        mre_o = miss_go;
        mwe_o = pop;
        ma_o  = '0;
        mwd_o = '0;
        if (miss_go) begin
            ma_o = da_i;
        end else if (pop) begin
            ma_o  = head_addr;
            mwd_o = head_data;
        end
    end

    always_comb begin
        state_d = ld_go ? StResp : StIdle;
        hit_d   = hit_q;
        fwd_d   = fwd_q;
        if (ld_go) begin
            hit_d = ld_hit;
            fwd_d = fifo_hit_data;
        end
    end

    always_ff @(posedge ck_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= StIdle;
            hit_q   <= 1'b0;
            fwd_q   <= '0;
        end else begin
            state_q <= state_d;
            hit_q   <= hit_d;
            fwd_q   <= fwd_d;
        end
    end

    always_comb begin
        rdv_o = (state_q == StResp);
        drd_o = '0;
        if (rdv_o) begin
            drd_o = hit_q ? fwd_q : mrd_i;
        end
    end

    assign empty_o = fifo_empty;

endmodule

// File: tb/tb_dmem_store_buffer.sv
// Directed bench for dmem_store_buffer with a registered-read RAM model on the memory side.
module tb_dmem_store_buffer;

    logic        ck, rst;
    logic [15:0] da, dwr, drd, ma, mwd, mrd;
    logic        rw, vld, stall, rdv, flush, empty, mgnt, mwe, mre;

    logic [15:0] ram [256];
    int          n_cmp = 0;
    int          n_bad = 0;

    dmem_store_buffer #(
        .AW    (16),
        .DW    (16),
        .DEPTH (4)
    ) dut (
        .ck_i    (ck),
        .rst_i   (rst),
        .da_i    (da),
        .dwr_i   (dwr),
        .rw_i    (rw),
        .vld_i   (vld),
        .stall_o (stall),
        .drd_o   (drd),
        .rdv_o   (rdv),
        .flush_i (flush),
        .empty_o (empty),
        .mgnt_i  (mgnt),
        .ma_o    (ma),
        .mwd_o   (mwd),
        .mwe_o   (mwe),
        .mre_o   (mre),
        .mrd_i   (mrd)
    );

    initial ck = 1'b0;
    always #5 ck = ~ck;

    // Single-port synchronous RAM: write on strobe, read data valid the cycle after MRE.
    always @(posedge ck) begin
        if (mwe) ram[ma[7:0]] <= mwd;
        if (mre) mrd <= ram[ma[7:0]];
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge ck);
        #1;
    endtask

    task automatic drive(input logic v, input logic r, input logic [15:0] a, input logic [15:0] d);
        vld = v;
        rw  = r;
        da  = a;
        dwr = d;
        #1;
    endtask

    initial begin
        for (int i = 0; i < 256; i++) ram[i] = 16'h0000;
        ram[8'h30] = 16'hBEEF;
        ram[8'h40] = 16'h4444;
        mrd   = 16'h0;
        rst   = 1'b1;
        flush = 1'b0;
        mgnt  = 1'b0;
        vld   = 1'b0;
        rw    = 1'b0;
        da    = 16'h0;
        dwr   = 16'h0;
        #2;
        chk("rst_stall", stall, 0);
        chk("rst_rdv", rdv, 0);
        chk("rst_drd", drd, 0);
        chk("rst_empty", empty, 1);
        chk("rst_mwe", mwe, 0);
        chk("rst_mre", mre, 0);
        chk("rst_ma", ma, 0);
        chk("rst_mwd", mwd, 0);
        #10 rst = 1'b0;
        tick();

        // Single store drains the following cycle.
        mgnt = 1'b1;
        drive(1, 0, 16'h0000, 16'h0004);
        chk("st1_stall", stall, 0);
        chk("st1_mwe_now", mwe, 0);
        tick();
        drive(0, 0, 16'h0, 16'h0);
        chk("st1_mwe", mwe, 1);
        chk("st1_ma", ma, 16'h0000);
        chk("st1_mwd", mwd, 16'h0004);
        tick();
        chk("st1_empty", empty, 1);
        chk("st1_ram", ram[0], 16'h0004);

        // Fill to DEPTH with the port withheld, fifth store stalls.
        mgnt = 1'b0;
        for (int i = 0; i < 4; i++) begin
            drive(1, 0, 16'h0010 + 16'(i), 16'h0100 + 16'(i));
            chk($sformatf("fill%0d_stall", i), stall, 0);
            tick();
        end
        drive(1, 0, 16'h0014, 16'h0104);
        chk("full_stall_a", stall, 1);
        chk("full_mwe", mwe, 0);
        tick();
        chk("full_stall_b", stall, 1);
        chk("full_empty", empty, 0);
        mgnt = 1'b1;
        #1;
        chk("full_pushpop_stall", stall, 0);
        chk("drain0_mwe", mwe, 1);
        chk("drain0_ma", ma, 16'h0010);
        chk("drain0_mwd", mwd, 16'h0100);
        tick();
        drive(0, 0, 16'h0, 16'h0);
        for (int i = 1; i < 5; i++) begin
            chk($sformatf("drain%0d_mwe", i), mwe, 1);
            chk($sformatf("drain%0d_ma", i), ma, 16'h0010 + 16'(i));
            chk($sformatf("drain%0d_mwd", i), mwd, 16'h0100 + 16'(i));
            tick();
        end
        chk("drain_empty", empty, 1);
        chk("drain_ram14", ram[8'h14], 16'h0104);

        // Forwarding picks the youngest of two stores to one address.
        mgnt = 1'b0;
        drive(1, 0, 16'h0020, 16'h0011);
        tick();
        drive(1, 0, 16'h0020, 16'h0022);
        tick();
        drive(1, 1, 16'h0020, 16'h0);
        chk("hit_stall", stall, 0);
        chk("hit_mre", mre, 0);
        tick();
        drive(0, 0, 16'h0, 16'h0);
        chk("hit_rdv", rdv, 1);
        chk("hit_drd", drd, 16'h0022);
        chk("hit_mre_after", mre, 0);
        tick();
        chk("hit_rdv_once", rdv, 0);

        // Miss without grant stalls and leaves the buffer alone.
        drive(1, 1, 16'h0040, 16'h0);
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("miss_wait%0d_stall", i), stall, 1);
            chk($sformatf("miss_wait%0d_mre", i), mre, 0);
            chk($sformatf("miss_wait%0d_mwe", i), mwe, 0);
            tick();
            chk($sformatf("miss_wait%0d_rdv", i), rdv, 0);
        end
        mgnt = 1'b1;
        #1;
        chk("miss_go_stall", stall, 0);
        chk("miss_go_mre", mre, 1);
        chk("miss_go_mwe", mwe, 0);
        chk("miss_go_ma", ma, 16'h0040);
        tick();
        drive(0, 0, 16'h0, 16'h0);
        chk("miss_rdv", rdv, 1);
        chk("miss_drd", drd, 16'h4444);
        chk("kept0_ma", ma, 16'h0020);
        chk("kept0_mwd", mwd, 16'h0011);
        tick();
        chk("kept1_ma", ma, 16'h0020);
        chk("kept1_mwd", mwd, 16'h0022);
        tick();
        chk("kept_empty", empty, 1);
        chk("kept_ram20", ram[8'h20], 16'h0022);

        // Back-to-back misses: RESP held, second read issued during first response.
        drive(1, 1, 16'h0030, 16'h0);
        chk("b2b0_mre", mre, 1);
        chk("b2b0_ma", ma, 16'h0030);
        tick();
        drive(1, 1, 16'h0040, 16'h0);
        chk("b2b0_rdv", rdv, 1);
        chk("b2b0_drd", drd, 16'hBEEF);
        chk("b2b1_mre", mre, 1);
        tick();
        drive(0, 0, 16'h0, 16'h0);
        chk("b2b1_rdv", rdv, 1);
        chk("b2b1_drd", drd, 16'h4444);
        tick();
        chk("b2b_idle_rdv", rdv, 0);
        chk("b2b_idle_drd", drd, 0);

        // Flush stalls stores; reset mid-drain drops what is left.
        mgnt = 1'b0;
        for (int i = 0; i < 3; i++) begin
            drive(1, 0, 16'h0050 + 16'(i), 16'h0500 + 16'(i));
            tick();
        end
        flush = 1'b1;
        mgnt  = 1'b1;
        drive(1, 0, 16'h0060, 16'h0600);
        chk("flush_st_stall", stall, 1);
        chk("flush_mwe", mwe, 1);
        chk("flush_ma", ma, 16'h0050);
        tick();
        drive(0, 0, 16'h0, 16'h0);
        chk("flush_next_ma", ma, 16'h0051);
        rst = 1'b1;
        #1;
        chk("rstmid_mwe", mwe, 0);
        chk("rstmid_ma", ma, 0);
        chk("rstmid_mwd", mwd, 0);
        chk("rstmid_empty", empty, 1);
        chk("rstmid_stall", stall, 0);
        chk("rstmid_rdv", rdv, 0);
        tick();
        rst = 1'b0;
        tick();
        tick();
        chk("rstmid_mwe_after", mwe, 0);
        chk("rstmid_ram50", ram[8'h50], 16'h0500);
        chk("rstmid_ram51", ram[8'h51], 16'h0000);
        chk("rstmid_ram52", ram[8'h52], 16'h0000);
        chk("rstmid_ram60", ram[8'h60], 16'h0000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
